inst_mem_loader: RTL and testbench

- Instruction-memory responder for the processor fetch port: serves `inst` for each `pcf` the core presents.
- Before execution, accepts a program over a valid/ready load stream into on-chip word storage.
- Holds the processor in reset until loading completes, then releases it.
- Sits between the boot/test source and the processor's `pcf`/`inst`/`rst` pins.

---
 rtl/inst_mem_loader.sv | 116 +++++++++++
 tb/tb_inst_mem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory with a valid/ready program loader; holds the core in reset
// until a program has been loaded, then serves fetches combinationally.
module inst_mem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [31:0]       pcf,
    output logic [WORD_W-1:0] inst,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   load_count,
    output logic              trunc
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                trunc_q, trunc_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                ready_q, ready_d;
    logic                xfer;
    logic [WORD_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic                hi_zero;
    logic                idx_loaded;

    // State and control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LOAD;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            trunc_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            trunc_q   <= trunc_d;
            cpu_rst_q <= cpu_rst_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic; reload takes priority over any transfer
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        trunc_d  = trunc_q;
        xfer     = 1'b0;
        case (state_q)
            LOAD: begin
                if (reload) begin
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                end else if (ld_valid && ready_q) begin
                    xfer     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (ld_last) begin
                        state_d = RUN;
                    end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = RUN;
                        trunc_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    trunc_d  = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
        ready_d   = (state_d == LOAD);
        cpu_rst_d = (state_d == LOAD);
    end

    // Program storage; contents survive reset
    always_ff @(posedge clk) begin
        if (rst && xfer) begin
            mem_q[wr_ptr_q] <= ld_data;
        end
    end

    // Zero-latency fetch; anything outside the loaded program reads as NOP
    assign idx        = pcf[ADDR_W+1:2];
    assign hi_zero    = ((pcf >> (ADDR_W + 2)) == 32'd0);
    assign idx_loaded = ({1'b0, idx} < cnt_q);
    assign inst       = (state_q == RUN && hi_zero && idx_loaded) ? mem_q[idx] : '0;

    assign ld_ready   = ready_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_count = cnt_q;
    assign trunc      = trunc_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: default instance (ADDR_W=8) and a
// small instance (ADDR_W=2) for the storage-full truncation path.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        ld_valid [2];
    logic [31:0] ld_data  [2];
    logic        ld_last  [2];
    logic        reload   [2];
    logic [31:0] pcf      [2];
    wire         rdy      [2];
    wire  [31:0] inst     [2];
    wire         cpu_rst  [2];
    wire         trunc    [2];
    wire  [8:0]  cnt      [2];
    wire  [8:0]  a_cnt;
    wire  [2:0]  b_cnt;

    assign cnt[0] = a_cnt;
    assign cnt[1] = {6'd0, b_cnt};

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(8), .WORD_W(32)) u_a (
        .clk(clk), .rst(rst[0]), .ld_valid(ld_valid[0]), .ld_ready(rdy[0]),
        .ld_data(ld_data[0]), .ld_last(ld_last[0]), .reload(reload[0]), .pcf(pcf[0]),
        .inst(inst[0]), .cpu_rst(cpu_rst[0]), .load_count(a_cnt), .trunc(trunc[0])
    );

    inst_mem_loader #(.ADDR_W(2), .WORD_W(32)) u_b (
        .clk(clk), .rst(rst[1]), .ld_valid(ld_valid[1]), .ld_ready(rdy[1]),
        .ld_data(ld_data[1]), .ld_last(ld_last[1]), .reload(reload[1]), .pcf(pcf[1]),
        .inst(inst[1]), .cpu_rst(cpu_rst[1]), .load_count(b_cnt), .trunc(trunc[1])
    );

    typedef struct {
        int          d;
        int          id;
        logic [31:0] inst;
        logic        cpu_rst;
        logic        rdy;
        logic        chk_rdy;
        logic [8:0]  cnt;
        logic        trunc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   next_id = 0;

    // Monitor: compare every pending expectation against the sampled outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if (inst[e.d] !== e.inst) begin
                n_fail++;
                $display("FAIL chk%0d dut%0d inst: got %h want %h", e.id, e.d, inst[e.d], e.inst);
            end
            n_chk++;
            if (cpu_rst[e.d] !== e.cpu_rst) begin
                n_fail++;
                $display("FAIL chk%0d dut%0d cpu_rst: got %b want %b", e.id, e.d, cpu_rst[e.d], e.cpu_rst);
            end
            n_chk++;
            if (cnt[e.d] !== e.cnt) begin
                n_fail++;
                $display("FAIL chk%0d dut%0d load_count: got %0d want %0d", e.id, e.d, cnt[e.d], e.cnt);
            end
            n_chk++;
            if (trunc[e.d] !== e.trunc) begin
                n_fail++;
                $display("FAIL chk%0d dut%0d trunc: got %b want %b", e.id, e.d, trunc[e.d], e.trunc);
            end
            if (e.chk_rdy) begin
                n_chk++;
                if (rdy[e.d] !== e.rdy) begin
                    n_fail++;
                    $display("FAIL chk%0d dut%0d ld_ready: got %b want %b", e.id, e.d, rdy[e.d], e.rdy);
                end
            end
        end
    end

    // Push an expectation for the current pcf, then let the monitor sample it
    task automatic expect_out(input int d, input logic [31:0] addr, input logic [31:0] e_inst,
                              input logic e_rst, input logic e_rdy, input logic chk_rdy,
                              input logic [8:0] e_cnt, input logic e_trunc);
        exp_t e;
        pcf[d]    = addr;
        e.d       = d;
        e.id      = next_id;
        e.inst    = e_inst;
        e.cpu_rst = e_rst;
        e.rdy     = e_rdy;
        e.chk_rdy = chk_rdy;
        e.cnt     = e_cnt;
        e.trunc   = e_trunc;
        next_id++;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input int d, input logic [31:0] data, input logic last);
        int n;
        ld_valid[d] = 1'b1;
        ld_data[d]  = data;
        ld_last[d]  = last;
        n = 0;
        while (rdy[d] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++;
        if (rdy[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout dut%0d: ld_ready=%b after %0d cycles, want 1", d, rdy[d], n);
        end
        @(posedge clk);
        #1;
        ld_valid[d] = 1'b0;
        ld_last[d]  = 1'b0;
    endtask

    task automatic pulse_reload(input int d);
        reload[d] = 1'b1;
        @(posedge clk);
        #1;
        reload[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; ld_valid[d] = 1'b0; ld_data[d] = '0;
            ld_last[d] = 1'b0; reload[d] = 1'b0; pcf[d] = '0;
        end
        @(posedge clk);
        #1;
        // Reset state: not ready, core held, nothing loaded
        expect_out(0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 9'd0, 1'b0);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        idle(1);
        expect_out(0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0);

        // Three-word program with a gap in the stream
        send_word(0, 32'h8080_0190, 1'b0);
        expect_out(0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 9'd1, 1'b0);
        idle(2);
        send_word(0, 32'h8100_012C, 1'b0);
        expect_out(0, 32'd4, 32'd0, 1'b1, 1'b1, 1'b1, 9'd2, 1'b0);
        send_word(0, 32'h0989_0000, 1'b1);
        expect_out(0, 32'd0,  32'h8080_0190, 1'b0, 1'b0, 1'b1, 9'd3, 1'b0);
        expect_out(0, 32'd4,  32'h8100_012C, 1'b0, 1'b0, 1'b1, 9'd3, 1'b0);
        expect_out(0, 32'd8,  32'h0989_0000, 1'b0, 1'b0, 1'b1, 9'd3, 1'b0);
        expect_out(0, 32'd12, 32'd0,         1'b0, 1'b0, 1'b1, 9'd3, 1'b0);
        expect_out(0, 32'd5,  32'h8100_012C, 1'b0, 1'b0, 1'b1, 9'd3, 1'b0);
        expect_out(0, 32'h400, 32'd0,        1'b0, 1'b0, 1'b1, 9'd3, 1'b0);

        // Stray ld_valid while running must not write
        ld_valid[0] = 1'b1; ld_data[0] = 32'hFFFF_FFFF; ld_last[0] = 1'b1;
        idle(1);
        ld_valid[0] = 1'b0; ld_last[0] = 1'b0;
        expect_out(0, 32'd0,  32'h8080_0190, 1'b0, 1'b0, 1'b1, 9'd3, 1'b0);
        expect_out(0, 32'd12, 32'd0,         1'b0, 1'b0, 1'b1, 9'd3, 1'b0);

        // Reload then a one-word program; old word 1 stays hidden
        pulse_reload(0);
        expect_out(0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0);
        send_word(0, 32'hDEAD_BEEF, 1'b1);
        expect_out(0, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 9'd1, 1'b0);
        expect_out(0, 32'd4, 32'd0,         1'b0, 1'b0, 1'b1, 9'd1, 1'b0);

        // Reset after two of four words, then a complete fresh load
        pulse_reload(0);
        send_word(0, 32'hA000_0000, 1'b0);
        send_word(0, 32'hA000_0001, 1'b0);
        expect_out(0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 9'd2, 1'b0);
        rst[0] = 1'b0;
        idle(1);
        expect_out(0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 9'd0, 1'b0);
        rst[0] = 1'b1;
        send_word(0, 32'hB000_0000, 1'b0);
        send_word(0, 32'hB000_0001, 1'b0);
        send_word(0, 32'hB000_0002, 1'b0);
        send_word(0, 32'hB000_0003, 1'b1);
        expect_out(0, 32'd12, 32'hB000_0003, 1'b0, 1'b0, 1'b1, 9'd4, 1'b0);
        expect_out(0, 32'd4,  32'hB000_0001, 1'b0, 1'b0, 1'b1, 9'd4, 1'b0);
        expect_out(0, 32'd16, 32'd0,         1'b0, 1'b0, 1'b1, 9'd4, 1'b0);

        // Small instance: fill storage without ld_last
        send_word(1, 32'h0000_0011, 1'b0);
        send_word(1, 32'h0000_0022, 1'b0);
        send_word(1, 32'h0000_0033, 1'b0);
        expect_out(1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 9'd3, 1'b0);
        send_word(1, 32'h0000_0044, 1'b0);
        expect_out(1, 32'd12, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 9'd4, 1'b1);
        expect_out(1, 32'd16, 32'd0,         1'b0, 1'b0, 1'b1, 9'd4, 1'b1);
        expect_out(1, 32'd1,  32'h0000_0011, 1'b0, 1'b0, 1'b1, 9'd4, 1'b1);

        // Reload clears trunc; reload inside LOAD discards the partial program
        pulse_reload(1);
        expect_out(1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0);
        send_word(1, 32'h0000_0066, 1'b0);
        expect_out(1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 9'd1, 1'b0);
        pulse_reload(1);
        expect_out(1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0);
        send_word(1, 32'h0000_0055, 1'b1);
        expect_out(1, 32'd0, 32'h0000_0055, 1'b0, 1'b0, 1'b1, 9'd1, 1'b0);
        expect_out(1, 32'd4, 32'd0,         1'b0, 1'b0, 1'b1, 9'd1, 1'b0);

        idle(2);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
